// File: rtl/noc_packet_injector_if.sv
// Local-channel bundle between a compute tile and the NoC injector: request, payload and
// injection-channel signals. master = injector side, slave = tile/fabric side.
interface noc_packet_injector_if #(
    parameter int unsigned Noc_Data_Width = 32,
    parameter int unsigned COORD_W        = 4,
    parameter int unsigned LEN_W          = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic [COORD_W-1:0]        req_dst_x;
    logic [COORD_W-1:0]        req_dst_y;
    logic [LEN_W-1:0]          req_len;

    logic                      pl_valid;
    logic                      pl_ready;
    logic [Noc_Data_Width-1:0] pl_data;

    logic                      inj_valid;
    logic                      inj_ready;
    logic [Noc_Data_Width-1:0] inj_flit;
    logic                      inj_vc_ready;
    logic                      inj_is_header;
    logic                      inj_is_tail;

    modport master (
        input  req_valid, req_dst_x, req_dst_y, req_len,
        input  pl_valid, pl_data,
        input  inj_ready, inj_vc_ready,
        output req_ready, pl_ready,
        output inj_valid, inj_flit, inj_is_header, inj_is_tail
    );

    modport slave (
        output req_valid, req_dst_x, req_dst_y, req_len,
        output pl_valid, pl_data,
        output inj_ready, inj_vc_ready,
        input  req_ready, pl_ready,
        input  inj_valid, inj_flit, inj_is_header, inj_is_tail
    );
endinterface

// File: rtl/noc_packet_injector.sv
// Packetizer for one NoC local channel: header flit then payload flits, wormhole VC hold.
// Define NOC_PACKET_INJECTOR_STATS_EN to add packet/flit/stall counter outputs.
module noc_packet_injector #(
    parameter int unsigned Noc_Data_Width = 32,
    parameter int unsigned COORD_W        = 4,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned SRC_X          = 0,
    parameter int unsigned SRC_Y          = 0
) (
    input  logic                         i_noc_clk,
    input  logic                         i_noc_rst,
    noc_packet_injector_if.master        inj_bus
`ifdef NOC_PACKET_INJECTOR_STATS_EN
    ,
    output logic [31:0]                  o_stat_pkt_cnt,
    output logic [31:0]                  o_stat_flit_cnt,
    output logic [31:0]                  o_stat_stall_cnt
`endif
);

    localparam int unsigned HdrW = LEN_W + 4 * COORD_W;
    localparam logic [COORD_W-1:0] SrcX = COORD_W'(SRC_X);
    localparam logic [COORD_W-1:0] SrcY = COORD_W'(SRC_Y);

    typedef enum logic [1:0] {
        StIdle,
        StWaitVc,
        StHead,
        StBody
    } state_e;

    state_e                    r_state,     w_state_nxt;
    logic [COORD_W-1:0]        r_dst_x,     w_dst_x_nxt;
    logic [COORD_W-1:0]        r_dst_y,     w_dst_y_nxt;
    logic [LEN_W-1:0]          r_len,       w_len_nxt;
    logic [LEN_W-1:0]          r_remaining, w_remaining_nxt;
    logic                      r_valid,     w_valid_nxt;
    logic [Noc_Data_Width-1:0] r_flit,      w_flit_nxt;
    logic                      r_is_header, w_is_header_nxt;
    logic                      r_is_tail,   w_is_tail_nxt;

    logic                      w_req_ready;
    logic                      w_pl_ready;
    logic                      w_flit_xfer;
    logic [Noc_Data_Width-1:0] w_header;

    always_comb begin
        w_header           = '0;
        w_header[HdrW-1:0] = {r_len, SrcY, SrcX, r_dst_y, r_dst_x};
    end

    assign w_flit_xfer = r_valid && inj_bus.inj_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_dst_x_nxt     = r_dst_x;
        w_dst_y_nxt     = r_dst_y;
        w_len_nxt       = r_len;
        w_remaining_nxt = r_remaining;
        w_valid_nxt     = r_valid;
        w_flit_nxt      = r_flit;
        w_is_header_nxt = r_is_header;
        w_is_tail_nxt   = r_is_tail;
        w_req_ready     = 1'b0;
        w_pl_ready      = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_req_ready = 1'b1;
                if (inj_bus.req_valid) begin
                    w_dst_x_nxt     = inj_bus.req_dst_x;
                    w_dst_y_nxt     = inj_bus.req_dst_y;
                    w_len_nxt       = inj_bus.req_len;
                    w_remaining_nxt = inj_bus.req_len;
                    w_state_nxt     = StWaitVc;
                end
            end

            StWaitVc: begin
                if (inj_bus.inj_vc_ready) begin
                    w_flit_nxt      = w_header;
                    w_valid_nxt     = 1'b1;
                    w_is_header_nxt = 1'b1;
                    w_is_tail_nxt   = (r_len == '0);
                    w_state_nxt     = StHead;
                end
            end

            StHead: begin
                // Open the payload port while the header drains so the first word follows it.
                w_pl_ready = inj_bus.inj_ready && (r_len != '0);
                if (w_flit_xfer) begin
                    if (r_len == '0) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = StBody;
                        if (inj_bus.pl_valid) begin
                            w_flit_nxt      = inj_bus.pl_data;
                            w_is_header_nxt = 1'b0;
                            w_is_tail_nxt   = (r_remaining == LEN_W'(1));
                            w_remaining_nxt = r_remaining - LEN_W'(1);
                        end else begin
                            w_valid_nxt = 1'b0;
                        end
                    end
                end
            end

            StBody: begin
                w_pl_ready = (!r_valid || inj_bus.inj_ready) && (r_remaining != '0);
                if (w_pl_ready && inj_bus.pl_valid) begin
                    w_flit_nxt      = inj_bus.pl_data;
                    w_valid_nxt     = 1'b1;
                    w_is_header_nxt = 1'b0;
                    w_is_tail_nxt   = (r_remaining == LEN_W'(1));
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                end else if (w_flit_xfer) begin
                    // Drained with nothing to replace it: a bubble, or the tail just left.
                    w_valid_nxt = 1'b0;
                    if (r_remaining == '0) begin
                        w_state_nxt = StIdle;
                    end
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_noc_clk) begin
        if (i_noc_rst) begin
            r_state     <= StIdle;
            r_dst_x     <= '0;
            r_dst_y     <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_flit      <= '0;
            r_is_header <= 1'b0;
            r_is_tail   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dst_x     <= w_dst_x_nxt;
            r_dst_y     <= w_dst_y_nxt;
            r_len       <= w_len_nxt;
            r_remaining <= w_remaining_nxt;
            r_valid     <= w_valid_nxt;
            r_flit      <= w_flit_nxt;
            r_is_header <= w_is_header_nxt;
            r_is_tail   <= w_is_tail_nxt;
        end
    end

    // Handshake readies are held low while reset is asserted so nothing is accepted.
    assign inj_bus.req_ready     = w_req_ready && !i_noc_rst;
    assign inj_bus.pl_ready      = w_pl_ready && !i_noc_rst;
    assign inj_bus.inj_valid     = r_valid;
    assign inj_bus.inj_flit      = r_flit;
    assign inj_bus.inj_is_header = r_is_header;
    assign inj_bus.inj_is_tail   = r_is_tail;

`ifdef NOC_PACKET_INJECTOR_STATS_EN
    logic [31:0] r_stat_pkt_cnt;
    logic [31:0] r_stat_flit_cnt;
    logic [31:0] r_stat_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_valid && !inj_bus.inj_ready) ||
                     ((r_state == StWaitVc) && !inj_bus.inj_vc_ready);

    always_ff @(posedge i_noc_clk) begin
        if (i_noc_rst) begin
            r_stat_pkt_cnt   <= '0;
            r_stat_flit_cnt  <= '0;
            r_stat_stall_cnt <= '0;
        end else begin
            if (w_flit_xfer) begin
                r_stat_flit_cnt <= r_stat_flit_cnt + 32'd1;
            end
            if (w_flit_xfer && r_is_tail) begin
                r_stat_pkt_cnt <= r_stat_pkt_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
            end
        end
    end

    assign o_stat_pkt_cnt   = r_stat_pkt_cnt;
    assign o_stat_flit_cnt  = r_stat_flit_cnt;
    assign o_stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: per-cycle vector table plus a randomized-free
// backpressure/bubble sequence with a flit scoreboard.
module tb_noc_packet_injector;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    noc_packet_injector_if #(
        .Noc_Data_Width(32),
        .COORD_W       (4),
        .LEN_W         (8)
    ) bus ();

`ifdef NOC_PACKET_INJECTOR_STATS_EN
    logic [31:0] stat_pkt;
    logic [31:0] stat_flit;
    logic [31:0] stat_stall;
`endif

    noc_packet_injector #(
        .Noc_Data_Width(32),
        .COORD_W       (4),
        .LEN_W         (8),
        .SRC_X         (0),
        .SRC_Y         (0)
    ) dut (
        .i_noc_clk       (clk),
        .i_noc_rst       (rst),
        .inj_bus         (bus)
`ifdef NOC_PACKET_INJECTOR_STATS_EN
        ,
        .o_stat_pkt_cnt  (stat_pkt),
        .o_stat_flit_cnt (stat_flit),
        .o_stat_stall_cnt(stat_stall)
`endif
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [7:0]  len;
        logic        pv;
        logic [31:0] pd;
        logic        ir;
        logic        vr;
        logic        e_rqr;
        logic        e_plr;
        logic        e_v;
        logic [31:0] e_f;
        logic        e_h;
        logic        e_t;
        logic        cf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic r, rv, input logic [3:0] dx, dy,
                                input logic [7:0] len, input logic pv, input logic [31:0] pd,
                                input logic ir, vr, rqr, plr, v, input logic [31:0] f,
                                input logic h, t, cf);
        vec_t x;
        x.rst = r;  x.rv = rv;  x.dx = dx;  x.dy = dy;  x.len = len;
        x.pv = pv;  x.pd = pd;  x.ir = ir;  x.vr = vr;
        x.e_rqr = rqr;  x.e_plr = plr;  x.e_v = v;  x.e_f = f;
        x.e_h = h;  x.e_t = t;  x.cf = cf;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst              = v.rst;
        bus.req_valid    = v.rv;
        bus.req_dst_x    = v.dx;
        bus.req_dst_y    = v.dy;
        bus.req_len      = v.len;
        bus.pl_valid     = v.pv;
        bus.pl_data      = v.pd;
        bus.inj_ready    = v.ir;
        bus.inj_vc_ready = v.vr;
    endtask

    initial begin
        int          fi;
        int          pi;
        logic        held;
        logic [31:0] held_flit;
        logic [31:0] exp_q[5];

        // rst rv dx dy len pv pd ir vr | rqr plr v flit h t cf
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1));
        // Header-only packet to (1,1)
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 32'h11, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        // Three payload flits, back-to-back
        vecs.push_back(mk(0, 1, 0, 1, 3, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA, 1, 1,  0, 1, 1, 32'h0003_0010, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB, 1, 1,  0, 1, 1, 32'hA, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC, 1, 1,  0, 1, 1, 32'hB, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 32'hC, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        // Backpressure on the second of three payload flits
        vecs.push_back(mk(0, 1, 2, 3, 3, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1111_1111, 1, 1,
                          0, 1, 1, 32'h0003_0032, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h2222_2222, 1, 1,
                          0, 1, 1, 32'h1111_1111, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3333_3333, 0, 1,
                              0, 0, 1, 32'h2222_2222, 0, 0, 1));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3333_3333, 1, 1,
                          0, 1, 1, 32'h2222_2222, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 32'h3333_3333, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        // VC wait, ignored requests while busy, VC drop mid-body
        vecs.push_back(mk(0, 1, 3, 0, 2, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(0, 1, 1, 1, 7, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA5, 1, 0,  0, 1, 1, 32'h0002_0003, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h5A, 1, 0,  0, 1, 1, 32'hA5, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 32'h5A, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
        // Payload bubbles of two cycles
        vecs.push_back(mk(0, 1, 1, 2, 2, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 32'h0002_0021, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100, 1, 1,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 32'h100, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h200, 1, 1,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 32'h200, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        // Reset after two of five payload flits, then a len=1 packet
        vecs.push_back(mk(0, 1, 0, 0, 5, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hD1, 1, 1,  0, 1, 1, 32'h0005_0000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hD2, 1, 1,  0, 1, 1, 32'hD1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hD3, 1, 1,  0, 0, 1, 32'hD2, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hD3, 1, 1,  0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 2, 2, 1, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hEE, 1, 1,  0, 1, 1, 32'h0001_0022, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 32'hEE, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0));

        drive(vecs[0]);
        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("req_ready", i, 32'(bus.req_ready), 32'(vecs[i].e_rqr));
            chk("pl_ready", i, 32'(bus.pl_ready), 32'(vecs[i].e_plr));
            chk("inj_valid", i, 32'(bus.inj_valid), 32'(vecs[i].e_v));
            if (vecs[i].cf || vecs[i].e_v) begin
                chk("inj_flit", i, bus.inj_flit, vecs[i].e_f);
                chk("is_header", i, 32'(bus.inj_is_header), 32'(vecs[i].e_h));
                chk("is_tail", i, 32'(bus.inj_is_tail), 32'(vecs[i].e_t));
            end
        end

`ifdef NOC_PACKET_INJECTOR_STATS_EN
        // Since the mid-body reset: one len=1 packet, two flits, no stalls.
        chk("stat_pkt", 0, stat_pkt, 32'd1);
        chk("stat_flit", 0, stat_flit, 32'd2);
        chk("stat_stall", 0, stat_stall, 32'd0);
`endif

        // Scoreboard sequence: len=4 to (3,3) with periodic inj_ready stalls, payload gaps
        // and a toggling vc_ready.
        exp_q[0] = 32'h0004_0033;
        for (int k = 1; k < 5; k++) begin
            exp_q[k] = 32'hC0DE_0000 + 32'(k - 1);
        end
        @(negedge clk);
        bus.req_valid = 1'b1;  bus.req_dst_x = 4'd3;  bus.req_dst_y = 4'd3;
        bus.req_len   = 8'd4;  bus.pl_valid  = 1'b0;  bus.inj_ready = 1'b1;
        bus.inj_vc_ready = 1'b1;
        #1;
        chk("hs_req_ready", 0, 32'(bus.req_ready), 32'd1);
        fi   = 0;
        pi   = 0;
        held = 1'b0;
        held_flit = '0;
        for (int cyc = 0; cyc < 200 && fi < 5; cyc++) begin
            @(negedge clk);
            bus.req_valid    = 1'b0;
            bus.inj_ready    = (cyc % 3) != 1;
            bus.pl_valid     = (pi < 4) && ((cyc % 4) != 2);
            bus.pl_data      = 32'hC0DE_0000 + 32'(pi);
            bus.inj_vc_ready = (cyc % 2) == 0;
            #1;
            if (held) begin
                chk("hs_hold_valid", fi, 32'(bus.inj_valid), 32'd1);
                chk("hs_hold_flit", fi, bus.inj_flit, held_flit);
            end
            held      = bus.inj_valid && !bus.inj_ready;
            held_flit = bus.inj_flit;
            if (bus.inj_valid && bus.inj_ready) begin
                chk("hs_flit", fi, bus.inj_flit, exp_q[fi]);
                chk("hs_header", fi, 32'(bus.inj_is_header), 32'(fi == 0));
                chk("hs_tail", fi, 32'(bus.inj_is_tail), 32'(fi == 4));
                fi++;
            end
            if (bus.pl_valid && bus.pl_ready) begin
                pi++;
            end
        end
        chk("hs_flits_done", 0, 32'(fi), 32'd5);
        chk("hs_payload_taken", 0, 32'(pi), 32'd4);
        @(negedge clk);
        bus.pl_valid = 1'b0;
        bus.inj_ready = 1'b1;
        #1;
        chk("hs_idle_req_ready", 0, 32'(bus.req_ready), 32'd1);
        chk("hs_idle_valid", 0, 32'(bus.inj_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
